// File: rtl/cache_pkg.sv
// Shared cache geometry and refill FSM encoding.
//   Default parameter values for the cache and its refill controller.
//   Derived byte-offset / line-offset widths for the default geometry.
//   refill_state_t: state encoding of the miss-refill FSM.
package cache_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 32;
    localparam int WORDS_PER_LINE_DEF = 4;

    // Bytes per word and the offset fields of a byte address.
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;
    localparam int BYTE_OFF_W     = $clog2(BYTES_PER_WORD);
    localparam int LINE_OFF_W     = $clog2(WORDS_PER_LINE_DEF);
    localparam int OFF_W          = BYTE_OFF_W + LINE_OFF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } refill_state_t;

endpackage : cache_pkg

// File: rtl/cache_refill_line_buf.sv
// Line assembly buffer for the refill controller.
//   WORDS x DATA_W register file, one indexed write port, flat read-out.
// Ports:
//   clk, rst_n     clock, async active-low reset (clears every word)
//   wr_en          write strobe
//   wr_idx         word slot to write
//   wr_data        word to store
//   line_flat      all words, word k at bits [k*DATA_W +: DATA_W]
module cache_refill_line_buf
    import cache_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WORDS  = WORDS_PER_LINE_DEF,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [WORDS*DATA_W-1:0] line_flat
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] mem_d [WORDS];

    // Next-state of the word array: only the addressed slot changes.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Word storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Flatten the array into the line layout the cache expects.
    always_comb begin
        line_flat = {(WORDS*DATA_W){1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            line_flat[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

endmodule : cache_refill_line_buf

// File: rtl/cache_refill_ctrl.sv
// Miss refill controller for the direct-mapped cache.
//   Accepts one miss at a time, fetches the aligned line word by word
//   (always in order 0..N-1) over a valid/ready request channel, then
//   presents the whole line for one cycle on the fill port.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   miss_valid/miss_addr/miss_ready miss handshake from the cache
//   mem_req_valid/addr/ready        word read request to memory
//   mem_rsp_valid/data              read data from memory (>=1 cycle after accept)
//   fill_valid/fill_addr/fill_line  one-cycle line write strobe to the cache;
//                                   addr/line hold their value until the next fill
//   busy                            refill in progress
// All outputs are registered: their next values are derived from the next state.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             miss_valid,
    input  logic [ADDR_W-1:0]                miss_addr,
    output logic                             miss_ready,
    output logic                             mem_req_valid,
    output logic [ADDR_W-1:0]                mem_req_addr,
    input  logic                             mem_req_ready,
    input  logic                             mem_rsp_valid,
    input  logic [DATA_W-1:0]                mem_rsp_data,
    output logic                             fill_valid,
    output logic [ADDR_W-1:0]                fill_addr,
    output logic [WORDS_PER_LINE*DATA_W-1:0] fill_line,
    output logic                             busy
);

    localparam int C_BYTE_OFF_W = $clog2(DATA_W / 8);
    localparam int C_LINE_OFF_W = $clog2(WORDS_PER_LINE);
    localparam int C_OFF_W      = C_BYTE_OFF_W + C_LINE_OFF_W;
    localparam int C_LINE_W     = WORDS_PER_LINE * DATA_W;
    localparam logic [C_LINE_OFF_W-1:0] C_LAST_IDX = C_LINE_OFF_W'(WORDS_PER_LINE - 1);

    refill_state_t             state_q,         state_d;
    logic [C_LINE_OFF_W-1:0]   cnt_q,           cnt_d;
    logic [ADDR_W-1:0]         base_q,          base_d;
    logic                      miss_ready_q,    miss_ready_d;
    logic                      busy_q,          busy_d;
    logic                      mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]         mem_req_addr_q,  mem_req_addr_d;
    logic                      fill_valid_q,    fill_valid_d;
    logic [ADDR_W-1:0]         fill_addr_q,     fill_addr_d;
    logic [C_LINE_W-1:0]       fill_line_q,     fill_line_d;

    logic                      buf_we_s;
    logic [C_LINE_W-1:0]       line_flat_s;
    logic [C_LINE_OFF_W-1:0]   cnt_nxt_s;
    logic [ADDR_W-1:0]         miss_base_s;

    cache_refill_line_buf #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS_PER_LINE),
        .IDX_W  (C_LINE_OFF_W)
    ) u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (buf_we_s),
        .wr_idx    (cnt_q),
        .wr_data   (mem_rsp_data),
        .line_flat (line_flat_s)
    );

    // Address helpers: aligned line base of the incoming miss, next word index.
    always_comb begin
        miss_base_s = {miss_addr[ADDR_W-1:C_OFF_W], {C_OFF_W{1'b0}}};
        cnt_nxt_s   = cnt_q + C_LINE_OFF_W'(1);
    end

    // FSM next-state and next values of all registered outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        base_d         = base_q;
        buf_we_s       = 1'b0;
        mem_req_addr_d = mem_req_addr_q;
        fill_valid_d   = 1'b0;
        fill_addr_d    = fill_addr_q;
        fill_line_d    = fill_line_q;

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    base_d         = miss_base_s;
                    cnt_d          = {C_LINE_OFF_W{1'b0}};
                    mem_req_addr_d = miss_base_s;
                    state_d        = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Request address was set on entry and stays put until accepted.
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    buf_we_s = 1'b1;
                    if (cnt_q == C_LAST_IDX) begin
                        // The last word is still being written into the buffer,
                        // so merge it straight into the outgoing line.
                        fill_line_d = line_flat_s;
                        fill_line_d[int'(cnt_q)*DATA_W +: DATA_W] = mem_rsp_data;
                        fill_addr_d  = base_q;
                        fill_valid_d = 1'b1;
                        state_d      = FILL;
                    end else begin
                        cnt_d          = cnt_nxt_s;
                        mem_req_addr_d = base_q | (ADDR_W'(cnt_nxt_s) << C_BYTE_OFF_W);
                        state_d        = REQ;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        miss_ready_d    = (state_d == IDLE);
        busy_d          = (state_d != IDLE);
        mem_req_valid_d = (state_d == REQ);
    end

    // FSM state, counter, line base and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= {C_LINE_OFF_W{1'b0}};
            base_q          <= {ADDR_W{1'b0}};
            miss_ready_q    <= 1'b1;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= {ADDR_W{1'b0}};
            fill_valid_q    <= 1'b0;
            fill_addr_q     <= {ADDR_W{1'b0}};
            fill_line_q     <= {C_LINE_W{1'b0}};
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            base_q          <= base_d;
            miss_ready_q    <= miss_ready_d;
            busy_q          <= busy_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            fill_valid_q    <= fill_valid_d;
            fill_addr_q     <= fill_addr_d;
            fill_line_q     <= fill_line_d;
        end
    end

    assign miss_ready    = miss_ready_q;
    assign busy          = busy_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign fill_valid    = fill_valid_q;
    assign fill_addr     = fill_addr_q;
    assign fill_line     = fill_line_q;

endmodule : cache_refill_ctrl

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl (default geometry: 32-bit addr/data, 4 words/line).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cache_refill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         miss_ready;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [127:0] fill_line;
    logic         busy;

    int n_vec;
    int n_miss;
    int cyc;

    cache_refill_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_ready    (miss_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_valid    (fill_valid),
        .fill_addr     (fill_addr),
        .fill_line     (fill_line),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Runs one complete refill starting at a falling edge with the DUT idle.
    // Memory data for word k is dbase+k. Returns at the falling edge after FILL.
    task automatic refill(input logic [31:0] addr, input logic [31:0] dbase,
                          input int req_stall, input int rsp_dly, input bit stray,
                          input bit hold_next, input logic [31:0] next_addr);
        logic [31:0]  base;
        logic [127:0] exp_line;
        bit           zero_wait;
        base      = addr & 32'hFFFF_FFF0;
        zero_wait = (req_stall == 0) && (rsp_dly == 0);
        for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = dbase + 32'(k);
        cyc = 0;
        chk("idle_miss_ready", {127'd0, miss_ready}, 128'd1);
        miss_valid    = 1'b1;
        miss_addr     = addr;
        mem_req_ready = (req_stall == 0);
        step();
        miss_valid = hold_next;
        miss_addr  = hold_next ? next_addr : 32'h0;
        for (int k = 0; k < 4; k++) begin
            // REQ for word k is visible now.
            chk("req_valid", {127'd0, mem_req_valid}, 128'd1);
            chk("req_addr", {96'd0, mem_req_addr}, {96'd0, base + 32'(4*k)});
            if (zero_wait) chk("req_cycle", 128'(cyc), 128'(1 + 2*k));
            if (hold_next) chk("busy_miss_ready", {127'd0, miss_ready}, 128'd0);
            if (stray) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEAD_BEEF;
            end
            for (int s = 0; s < req_stall; s++) begin
                step();
                mem_rsp_valid = 1'b0;
                chk("stall_req_valid", {127'd0, mem_req_valid}, 128'd1);
                chk("stall_req_addr", {96'd0, mem_req_addr}, {96'd0, base + 32'(4*k)});
            end
            mem_req_ready = 1'b1;
            step();
            // WAIT for word k.
            mem_req_ready = (req_stall == 0);
            mem_rsp_valid = 1'b0;
            chk("wait_req_valid", {127'd0, mem_req_valid}, 128'd0);
            for (int d = 0; d < rsp_dly; d++) begin
                step();
                chk("wait_busy", {127'd0, busy}, 128'd1);
                chk("wait_fill_valid", {127'd0, fill_valid}, 128'd0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = dbase + 32'(k);
            step();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
        // FILL cycle.
        chk("fill_valid", {127'd0, fill_valid}, 128'd1);
        chk("fill_addr", {96'd0, fill_addr}, {96'd0, base});
        chk("fill_line", fill_line, exp_line);
        if (zero_wait) chk("fill_cycle", 128'(cyc), 128'd9);
        if (hold_next) chk("fill_miss_ready", {127'd0, miss_ready}, 128'd0);
        step();
        chk("fill_one_cycle", {127'd0, fill_valid}, 128'd0);
        chk("post_idle_ready", {127'd0, miss_ready}, 128'd1);
        chk("post_idle_busy", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        miss_valid    = 1'b0;
        miss_addr     = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;

        // 1: reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            miss_valid    = 1'($urandom);
            miss_addr     = $urandom;
            mem_req_ready = 1'($urandom);
            mem_rsp_valid = 1'($urandom);
            mem_rsp_data  = $urandom;
            @(negedge clk);
            chk("rst_miss_ready", {127'd0, miss_ready}, 128'd1);
            chk("rst_busy", {127'd0, busy}, 128'd0);
            chk("rst_req_valid", {127'd0, mem_req_valid}, 128'd0);
            chk("rst_fill_valid", {127'd0, fill_valid}, 128'd0);
            chk("rst_fill_line", fill_line, 128'd0);
        end
        chk("rst_req_addr", {96'd0, mem_req_addr}, 128'd0);
        chk("rst_fill_addr", {96'd0, fill_addr}, 128'd0);
        miss_valid    = 1'b0;
        miss_addr     = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        rst_n = 1'b1;
        @(negedge clk);

        // 2: basic zero-wait refill.
        refill(32'h0000_0008, 32'hA0, 0, 0, 1'b0, 1'b0, 32'h0);
        chk("basic_line_const", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("hold_fill_addr", {96'd0, fill_addr}, 128'h0);
        chk("hold_fill_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("hold_fill_valid", {127'd0, fill_valid}, 128'd0);

        // 3: request and response stalls.
        refill(32'h0000_1234, 32'h0000_0300, 3, 2, 1'b0, 1'b0, 32'h0);

        // 4: miss held while busy, stray responses in REQ, back-to-back refill.
        refill(32'h0000_0040, 32'hB0, 0, 0, 1'b1, 1'b1, 32'h0000_0100);
        refill(32'h0000_0100, 32'hC0, 0, 0, 1'b0, 1'b0, 32'h0);
        chk("b2b_fill_addr", {96'd0, fill_addr}, 128'h100);

        // 5: reset mid-refill after word 1 returns.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_0060;
        mem_req_ready = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'h0000_0E00 + 32'(k);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
        end
        chk("mid_req_addr_w2", {96'd0, mem_req_addr}, 128'h68);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {127'd0, miss_ready}, 128'd1);
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_req_valid", {127'd0, mem_req_valid}, 128'd0);
        chk("mid_rst_fill_line", fill_line, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        chk("late_rsp_fill_valid", {127'd0, fill_valid}, 128'd0);
        chk("late_rsp_busy", {127'd0, busy}, 128'd0);
        chk("late_rsp_fill_line", fill_line, 128'd0);
        refill(32'h0000_0020, 32'hD0, 0, 0, 1'b0, 1'b0, 32'h0);
        chk("after_rst_fill_addr", {96'd0, fill_addr}, 128'h20);

        // 6: top of address space, no wrap.
        refill(32'hFFFF_FFFC, 32'h0000_5000, 0, 0, 1'b0, 1'b0, 32'h0);
        chk("top_fill_addr", {96'd0, fill_addr}, 128'hFFFF_FFF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_cache_refill_ctrl
